// File: rtl/fifo_lector.sv
// Read-side controller for a synchronous FIFO: issues reads under a credit limit,
// captures the returned words into a 2-entry skid buffer and hands them downstream.
module fifo_lector #(
  parameter int tamano_datos    = 10,
  parameter int tamano_direcion = 3,
  parameter int ancho_contador  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      habilitar,
  input  logic                      empty,
  input  logic                      almost_empty,
  input  logic                      error,
  input  logic [tamano_datos-1:0]   data_out,
  output logic                      read_enable,
  output logic                      out_valid,
  output logic [tamano_datos-1:0]   out_data,
  input  logic                      out_ready,
  output logic                      casi_vacio,
  output logic                      error_lector,
  output logic [ancho_contador-1:0] palabras
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACTIVE, S_ERROR} estado_t;

  // A single-entry FIFO can never have two words outstanding.
  localparam logic [2:0] CREDITO = (tamano_direcion == 0) ? 3'd1 : 3'd2;

  estado_t                          state, state_n;
  logic [1:0][tamano_datos-1:0]     skid, skid_n;
  logic [1:0]                       occ, occ_n, occ_rest;
  logic                             in_flight, pop, overflow, store;
  logic [2:0]                       pend;

  assign out_valid = (occ != 2'd0);
  assign out_data  = skid[0];
  assign pop       = out_valid & out_ready;

  // Words that will still be held after this cycle's pop, counting the in-flight one.
  assign occ_rest    = occ - {1'b0, pop};
  assign pend        = {1'b0, occ_rest} + {2'b00, in_flight};
  assign read_enable = (state == S_ACTIVE) & habilitar & ~empty & (pend < CREDITO);

  assign overflow = in_flight & (occ_rest == 2'd2);
  assign store    = in_flight & ~overflow;

  always_comb begin
    skid_n = skid;
    if (pop)   skid_n[0] = skid[1];
    if (store) skid_n[occ_rest[0]] = data_out;
    occ_n = occ_rest + {1'b0, store};
  end

  always_comb begin
    state_n = state;
    case (state)
      S_INIT:   state_n = S_IDLE;
      S_IDLE:   if (habilitar)  state_n = S_ACTIVE;
      S_ACTIVE: if (!habilitar) state_n = S_IDLE;
      S_ERROR:  state_n = S_ERROR;
      default:  state_n = S_INIT;
    endcase
    if (state != S_INIT && (error || overflow)) state_n = S_ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_INIT;
      skid         <= '0;
      occ          <= 2'd0;
      in_flight    <= 1'b0;
      casi_vacio   <= 1'b0;
      error_lector <= 1'b0;
      palabras     <= '0;
    end else begin
      state      <= state_n;
      skid       <= skid_n;
      occ        <= occ_n;
      in_flight  <= read_enable;
      casi_vacio <= almost_empty;
      if (state_n == S_ERROR) error_lector <= 1'b1;
      if (pop) palabras <= palabras + ancho_contador'(1);
    end
  end

endmodule

// File: tb/tb_fifo_lector.sv
// Directed bench for fifo_lector: a behavioural FIFO feeds the reader, and a
// second instance with a 4-bit counter covers the word-count wrap.
module tb_fifo_lector;
  localparam int W = 10;

  logic clk = 1'b0, reset = 1'b1, habilitar = 1'b0, error = 1'b0, out_ready = 1'b0;
  logic empty, almost_empty, read_enable, out_valid, casi_vacio, error_lector;
  logic [W-1:0]  data_out, out_data;
  logic [15:0]   palabras;
  logic [W-1:0]  mem [0:63];
  int            rd_ptr = 0, wr_ptr = 0;
  int            total = 0, bad = 0;

  logic          reset2 = 1'b1, out_ready2 = 1'b1, hab2 = 1'b1, zero2 = 1'b0;
  logic [W-1:0]  data2 = 10'h2A5, od2;
  logic          re2, ov2, cv2, el2;
  logic [3:0]    pal2;

  always #5 clk = ~clk;

  assign empty        = (rd_ptr == wr_ptr);
  assign almost_empty = ((wr_ptr - rd_ptr) == 1);

  fifo_lector #(.tamano_datos(W), .tamano_direcion(3), .ancho_contador(16)) dut (
    .clk(clk), .reset(reset), .habilitar(habilitar), .empty(empty),
    .almost_empty(almost_empty), .error(error), .data_out(data_out),
    .read_enable(read_enable), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .casi_vacio(casi_vacio), .error_lector(error_lector),
    .palabras(palabras)
  );

  fifo_lector #(.tamano_datos(W), .tamano_direcion(3), .ancho_contador(4)) dut_wrap (
    .clk(clk), .reset(reset2), .habilitar(hab2), .empty(zero2),
    .almost_empty(zero2), .error(zero2), .data_out(data2),
    .read_enable(re2), .out_valid(ov2), .out_data(od2),
    .out_ready(out_ready2), .casi_vacio(cv2), .error_lector(el2),
    .palabras(pal2)
  );

  // Registered-output FIFO: read data appears the edge after an accepted read.
  always @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= 0;
      data_out <= '0;
    end else if (read_enable && !empty) begin
      data_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_load(input int n);
    reset = 1'b1; habilitar = 1'b0; out_ready = 1'b0; error = 1'b0;
    @(negedge clk);
    wr_ptr = 0;
    for (int i = 0; i < n; i++) mem[i] = W'(i + 1);
    wr_ptr = n;
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] q[$];
    int nre, viol, hs, hs2;
    bit done;

    // reset state
    @(negedge clk);
    chk("rst_re", read_enable, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_casi", casi_vacio, 0);
    chk("rst_err", error_lector, 0);
    chk("rst_pal", palabras, 0);

    // streaming at full rate
    reset_load(8); habilitar = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t1_re", read_enable, (i >= 1 && i <= 8));
      chk("t1_valid", out_valid, (i >= 3 && i <= 10));
      if (i >= 3 && i <= 10) chk("t1_data", out_data, i - 2);
      chk("t1_casi", casi_vacio, (i == 9));
    end
    chk("t1_pal", palabras, 8);

    // full backpressure, then release
    reset_load(8); habilitar = 1'b1; out_ready = 1'b0; nre = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (read_enable) nre++;
    end
    chk("t2_nreads", nre, 2);
    chk("t2_rdptr", rd_ptr, 2);
    chk("t2_valid", out_valid, 1);
    chk("t2_hold", out_data, 1);
    out_ready = 1'b1; q.delete();
    for (int k = 0; k < 20; k++) begin
      #1;
      if (out_valid && out_ready) q.push_back(out_data);
      @(negedge clk);
    end
    chk("t2_count", q.size(), 8);
    for (int k = 0; k < 8; k++) chk("t2_order", (k < q.size()) ? q[k] : '1, k + 1);
    chk("t2_pal", palabras, 8);

    // alternating consumer readiness
    reset_load(8); habilitar = 1'b1; viol = 0; hs = 0; q.delete();
    for (int k = 0; k < 40; k++) begin
      out_ready = (k % 2 == 0);
      #1;
      if (read_enable && (rd_ptr - hs - ((out_valid && out_ready) ? 1 : 0)) >= 2) viol++;
      if (out_valid && out_ready) begin q.push_back(out_data); hs++; end
      @(negedge clk);
    end
    chk("t3_credit", viol, 0);
    chk("t3_count", q.size(), 8);
    for (int k = 0; k < 8; k++) chk("t3_order", (k < q.size()) ? q[k] : '1, k + 1);

    // enable dropped with one read in flight
    reset_load(8); habilitar = 1'b1; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("t4_re_on", read_enable, 1);
    @(negedge clk);
    habilitar = 1'b0; #1;
    chk("t4_re_drop", read_enable, 0);
    @(negedge clk);
    chk("t4_valid", out_valid, 1);
    chk("t4_data", out_data, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_re_idle", read_enable, 0);
      chk("t4_drained", out_valid, 0);
    end
    chk("t4_rdptr", rd_ptr, 1);
    chk("t4_pal", palabras, 1);
    habilitar = 1'b1; #1;
    chk("t4_idle_state", read_enable, 0);
    @(negedge clk);
    chk("t4_reactivate", read_enable, 1);
    habilitar = 1'b0;

    // error with two buffered words
    reset_load(8); habilitar = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("t5_full", out_valid, 1);
    error = 1'b1;
    @(negedge clk);
    error = 1'b0;
    chk("t5_err", error_lector, 1);
    chk("t5_re", read_enable, 0);
    chk("t5_data", out_data, 1);
    out_ready = 1'b1; nre = 0; q.delete();
    for (int k = 0; k < 10; k++) begin
      #1;
      if (read_enable) nre++;
      if (out_valid && out_ready) q.push_back(out_data);
      @(negedge clk);
    end
    chk("t5_noreads", nre, 0);
    chk("t5_drain_n", q.size(), 2);
    chk("t5_drain_1", (q.size() > 0) ? q[0] : '1, 1);
    chk("t5_drain_2", (q.size() > 1) ? q[1] : '1, 2);
    chk("t5_pal", palabras, 2);
    chk("t5_sticky", error_lector, 1);
    chk("t5_rdptr", rd_ptr, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_err", error_lector, 0);
    chk("t5_rst_pal", palabras, 0);
    chk("t5_rst_valid", out_valid, 0);
    reset = 1'b0;

    // 4-bit word counter wrap after 17 handshakes
    reset2 = 1'b0; hs2 = 0; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (ov2 && out_ready2) begin
        hs2++;
        if (hs2 == 17) begin
          @(posedge clk);
          #1;
          out_ready2 = 1'b0;
          done = 1'b1;
        end
      end
    end
    chk("t6_reached", done, 1);
    chk("t6_wrap", pal2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
